// File: rtl/wishbone_master_pkg.sv
// Shared types and constants for the Wishbone single-transfer master.
package wishbone_master_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 32'h10;
  localparam logic [ADDR_W-1:0] ADDR_CMD  = 32'h20;

  // Outbound cycle payload held stable for the whole bus cycle
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
  } wb_cmd_t;

  // Reads put zero on the write-data lines
  function automatic logic [DATA_W-1:0] write_payload(input logic we,
                                                      input logic [DATA_W-1:0] data);
    return we ? data : '0;
  endfunction

endpackage

// File: rtl/wishbone_master.sv
// Single-outstanding-transfer Wishbone master with ack timeout and a drain
// state that waits out level-held slave acks before accepting new work.
module wishbone_master
  import wishbone_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] wb_addr,
  output logic        wb_we,
  output logic        wb_stb,
  output logic        wb_cyc,
  output logic [31:0] wb_dout,
  input  logic [31:0] wb_din,
  input  logic        wb_ack
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  wb_cmd_t           cmd_q, cmd_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  assign req_ready = (state_q == IDLE) & ~wb_ack;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    cmd_d       = cmd_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d    = BUS;
          cnt_d      = '0;
          cyc_d      = 1'b1;
          cmd_d.we   = req_we;
          cmd_d.addr = req_addr;
          cmd_d.dout = write_payload(req_we, req_data);
        end
      end
      BUS: begin
        // Ack takes priority over an expiring timeout
        if (wb_ack) begin
          state_d     = DRAIN;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = cmd_q.we ? '0 : wb_din;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = DRAIN;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (!wb_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      cmd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign wb_cyc    = cyc_q;
  assign wb_stb    = cyc_q;
  assign wb_we     = cmd_q.we;
  assign wb_addr   = cmd_q.addr;
  assign wb_dout   = cmd_q.dout;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/wishbone_master.md
WISHBONE_MASTER -- requirements
Module: wishbone_master

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, max cycles in BUS awaiting wb_ack before abort (2..255).
REQ-002 SHALL have parameter: CNT_W, 8, timeout counter width.
REQ-003 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  system reset, asynchronous, active-high.
REQ-005 SHALL have ports: req_valid input 1 request present; req_ready output 1 request accepted when both high.
REQ-006 SHALL have ports: req_we input 1 write/read select; req_addr input 32 target address; req_data input 32 write data.
REQ-007 SHALL have ports: rsp_valid output 1 one-cycle response strobe; rsp_data output 32 read data; rsp_err output 1 timeout flag.
REQ-008 SHALL have ports: wb_addr output 32; wb_we output 1; wb_stb output 1; wb_cyc output 1; wb_dout output 32 bus to slave.
REQ-009 SHALL have ports: wb_din input 32 slave to bus; wb_ack input 1 slave acknowledge.

Function
REQ-010 SHALL implement states IDLE, BUS, DRAIN; all outputs registered except req_ready.
REQ-011 req_ready SHALL equal (state==IDLE) & ~wb_ack.
REQ-012 On acceptance in IDLE, next cycle SHALL drive wb_cyc=wb_stb=1, wb_addr=req_addr, wb_we=req_we, wb_dout=req_we?req_data:0, state BUS, counter=0.
REQ-013 In BUS, wb_addr/wb_we/wb_dout/wb_cyc/wb_stb SHALL remain stable; counter increments each cycle without ack.
REQ-014 On wb_ack=1 in BUS: next cycle wb_cyc=wb_stb=0, rsp_valid=1 for exactly one cycle, rsp_err=0, rsp_data=wb_we?0:wb_din sampled at the ack edge; state DRAIN.
REQ-015 When counter reaches TIMEOUT-1 with wb_ack=0: next cycle wb_cyc=wb_stb=0, rsp_valid=1 one cycle, rsp_err=1, rsp_data=0; state DRAIN.
REQ-016 Ack and timeout in same cycle: ack SHALL win (success response).
REQ-017 Minimum BUS duration SHALL be 1 cycle (ack present in first BUS cycle completes it).
REQ-018 DRAIN SHALL hold wb_cyc=wb_stb=0 and return to IDLE on the first cycle wb_ack=0; a level-held slave ack SHALL never complete a second transfer.
REQ-019 wb_ack outside BUS SHALL be ignored (no response generated).
REQ-020 rsp_data/rsp_err SHALL hold their last values when rsp_valid=0; wb_addr/wb_we/wb_dout SHALL hold after cycle end.
REQ-021 Back-to-back: next request SHALL be acceptable no earlier than the cycle after DRAIN exits, giving >=1 idle bus cycle between transfers.

Reset
REQ-022 rst=1 SHALL immediately force: state IDLE, counter 0, wb_cyc=wb_stb=wb_we=0, wb_addr=0, wb_dout=0, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-023 Reset during BUS SHALL abort the transfer with no rsp_valid; first acceptance possible the first clk edge after rst deasserts with wb_ack=0.

Structure
REQ-024 Shared package SHALL hold state encodings (IDLE=2'd0, BUS=2'd1, DRAIN=2'd2) and peripheral addresses ADDR_DATA=32'h10, ADDR_CMD=32'h20.
REQ-025 No sub-module; timeout counter and FSM SHALL live in wishbone_master.

Verification
REQ-026 Write addr 0x20 data 0x5A5, slave acks 3 cycles after cyc rises -> cyc/stb/we high 4 cycles, wb_dout=0x5A5, rsp_valid 1 cycle, rsp_err=0.
REQ-027 Read addr 0x10, slave returns wb_din=0x1A5 with ack -> rsp_data=0x000001A5, wb_we=0, wb_dout=0.
REQ-028 TIMEOUT=16, slave never acks -> cyc drops after exactly 16 BUS cycles, rsp_err=1, rsp_data=0.
REQ-029 Slave holds ack 3 cycles, req_valid held high -> req_ready low until ack low; exactly one response; second transfer starts afterwards.
REQ-030 TIMEOUT=16, ack in 16th BUS cycle -> success response, rsp_err=0.
REQ-031 rst asserted mid-BUS (asynchronous to clk) -> cyc/stb low before next edge, no rsp_valid; later read completes normally.
